div_unit: RTL and testbench
===========================

# div_unit

Sequential signed 32-bit divider for the MIPS datapath; the inverse counterpart of the Booth multiplier, sharing its start/stop handshake and HI/LO result convention. It implements DIV semantics: quotient to LO, remainder to HI, remainder sign follows the dividend. It uses a restoring shift-subtract algorithm at one quotient bit per cycle on unsigned magnitudes, then applies a sign fix-up. The control unit pulses start, stalls until stop, then latches HI/LO.

## Interface
- Parameters: none (datapath fixed at 32 bits).
- Clock  in  1  rising-edge clock.
- Reset  in  1  asynchronous, active-low (0 = reset); clears all state immediately.
- w_DivStart  in  1  start request; sampled only in IDLE.
- w_A  in  32  dividend, signed two's complement; sampled with start.
- w_B  in  32  divisor, signed two's complement; sampled with start.
- w_DivStop  out  1  completion pulse, exactly one cycle wide.
- w_DIVHI  out  32  remainder.
- w_DIVLO  out  32  quotient.
- w_DivZero  out  1  set when the last operation had w_B == 0; valid with w_DivStop.

## Operation
- States: IDLE, RUN, FIX, DONE.
- Reset (Reset = 0, async): state = IDLE, w_DivStop = 0, w_DIVHI = 0, w_DIVLO = 0, w_DivZero = 0, counter = 0, internal registers = 0.
- IDLE with w_DivStart = 1 and w_B != 0:
  - Latch |w_A| into the dividend/quotient register Q and |w_B| into divisor D.
  - Compute |x| as the two's complement when negative. |0x80000000| = 0x80000000 as unsigned, which is correct.
  - Latch sign flags: sq = A[31]^B[31], sr = A[31].
  - Clear the remainder register R (33 bits), set counter = 32, clear w_DivZero, go to RUN.
- IDLE with w_DivStart = 1 and w_B == 0:
  - Set w_DIVLO = 32'hFFFFFFFF, w_DIVHI = w_A, w_DivZero = 1.
  - Go to DONE; no iterations are performed.
- RUN, per cycle:
  - {R,Q} shift left by 1; T = R - {1'b0,D}.
  - If T is non-negative (bit 32 = 0): R = T, Q[0] = 1. Otherwise R is unchanged and Q[0] = 0.
  - counter decrements by 1; when it reaches 0, go to FIX.
- FIX:
  - w_DIVLO = sq ? -Q : Q; w_DIVHI = sr ? -R[31:0] : R[31:0].
  - All arithmetic is modulo 2^32. Therefore 0x80000000 / -1 gives LO = 0x80000000, HI = 0 with no trap.
  - Go to DONE.
- DONE: w_DivStop = 1 for this cycle only; next state IDLE.
- w_DivStart asserted in RUN, FIX or DONE is ignored. Operands are never resampled mid-operation.
- w_DIVHI, w_DIVLO and w_DivZero hold their values until the next FIX or divide-by-zero completion, or until reset.
- Reset asserted mid-operation aborts the operation immediately. After release the block sits in IDLE with all outputs at 0 and no stop pulse.

## Timing
- Start sampled at edge N (state IDLE):
  - Normal case: iterations on edges N+1..N+32, FIX on edge N+33, w_DivStop high from edge N+34 to edge N+35. Latency is 34 cycles from start to stop.
  - Divide by zero: w_DivStop high from edge N+1 to edge N+2, with results already valid.
- Results are valid in the same cycle as w_DivStop and remain stable afterwards.
- Start held high continuously: a new operation begins on the first IDLE edge after DONE. Back-to-back throughput is one division per 35 cycles.
- No combinational path from inputs to outputs.

## Test plan
- A = 100, B = 7, start one cycle -> after 34 cycles w_DivStop pulses once; LO = 14, HI = 2, w_DivZero = 0.
- A = -100, B = 7 -> LO = 0xFFFFFFF2, HI = 0xFFFFFFFE. A = 100, B = -7 -> LO = 0xFFFFFFF2, HI = 2. A = -100, B = -7 -> LO = 14, HI = 0xFFFFFFFE.
- A = 0x80000000, B = 0xFFFFFFFF -> LO = 0x80000000, HI = 0. A = 0x80000000, B = 1 -> LO = 0x80000000, HI = 0. A = 5, B = 9 -> LO = 0, HI = 5.
- A = 0x12345678, B = 0 -> stop pulses 1 cycle after start; LO = 0xFFFFFFFF, HI = 0x12345678, w_DivZero = 1.
- Start A = 100, B = 7. Toggle start with A = 1, B = 1 during RUN -> ignored; result is still LO = 14, HI = 2 at the original cycle.
- Start, then drive Reset = 0 asynchronously at cycle 10 (between clock edges) -> all outputs go to 0 immediately and no stop pulse follows. A new start after release gives correct results. Randomized signed pairs are checked against a $signed / and % reference model.

Source files
------------

// File: rtl/div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : div_unit
//  Description : Sequential signed 32-bit divider (MIPS DIV semantics).
//                Restoring shift-subtract on unsigned magnitudes, one
//                quotient bit per cycle, followed by a sign fix-up.
//                Quotient -> LO, remainder -> HI. The remainder takes the
//                sign of the dividend.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    Clock       in   1   rising-edge clock
//    Reset       in   1   asynchronous active-low reset
//    w_DivStart  in   1   start request, sampled only in IDLE
//    w_A         in  32   dividend (signed), sampled with start
//    w_B         in  32   divisor  (signed), sampled with start
//    w_DivStop   out  1   one-cycle completion pulse
//    w_DIVHI     out 32   remainder
//    w_DIVLO     out 32   quotient
//    w_DivZero   out  1   last operation had a zero divisor
// ============================================================================
module div_unit (
   input  logic        Clock,
   input  logic        Reset,
   input  logic        w_DivStart,
   input  logic [31:0] w_A,
   input  logic [31:0] w_B,
   output logic        w_DivStop,
   output logic [31:0] w_DIVHI,
   output logic [31:0] w_DIVLO,
   output logic        w_DivZero
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_FIX  = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   logic [1:0]  state_q, state_d;
   logic [31:0] r_q,     r_d;      // partial remainder
   logic [31:0] q_q,     q_d;      // dividend shifting out / quotient shifting in
   logic [31:0] d_q,     d_d;      // divisor magnitude
   logic [5:0]  cnt_q,   cnt_d;
   logic        sq_q,    sq_d;     // quotient sign
   logic        sr_q,    sr_d;     // remainder sign
   logic        stop_q,  stop_d;
   logic [31:0] hi_q,    hi_d;
   logic [31:0] lo_q,    lo_d;
   logic        zero_q,  zero_d;

   // Magnitudes; |0x80000000| wraps to 0x80000000, which is the correct
   // unsigned magnitude.
   logic [31:0] abs_a, abs_b;
   assign abs_a = w_A[31] ? (~w_A + 32'd1) : w_A;
   assign abs_b = w_B[31] ? (~w_B + 32'd1) : w_B;

   // The remainder stays below the divisor (<= 2^31), so the shifted
   // remainder fits in 33 bits and the stored remainder in 32.
   logic [32:0] rem_sh;
   logic [32:0] trial;
   assign rem_sh = {r_q, q_q[31]};
   assign trial  = rem_sh - {1'b0, d_q};

   always_comb begin
      state_d = state_q;
      r_d     = r_q;
      q_d     = q_q;
      d_d     = d_q;
      cnt_d   = cnt_q;
      sq_d    = sq_q;
      sr_d    = sr_q;
      stop_d  = 1'b0;
      hi_d    = hi_q;
      lo_d    = lo_q;
      zero_d  = zero_q;

      case (state_q)
         ST_IDLE: begin
            if (w_DivStart) begin
               if (w_B == 32'd0) begin
                  lo_d    = 32'hFFFF_FFFF;
                  hi_d    = w_A;
                  zero_d  = 1'b1;
                  state_d = ST_DONE;
               end else begin
                  q_d     = abs_a;
                  d_d     = abs_b;
                  sq_d    = w_A[31] ^ w_B[31];
                  sr_d    = w_A[31];
                  r_d     = 32'd0;
                  cnt_d   = 6'd32;
                  zero_d  = 1'b0;
                  state_d = ST_RUN;
               end
            end
         end

         ST_RUN: begin
            if (!trial[32]) begin
               r_d = trial[31:0];
               q_d = {q_q[30:0], 1'b1};
            end else begin
               r_d = rem_sh[31:0];
               q_d = {q_q[30:0], 1'b0};
            end
            cnt_d = cnt_q - 6'd1;
            if (cnt_q == 6'd1) begin
               state_d = ST_FIX;
            end
         end

         ST_FIX: begin
            lo_d    = sq_q ? (~q_q + 32'd1) : q_q;
            hi_d    = sr_q ? (~r_q + 32'd1) : r_q;
            state_d = ST_DONE;
         end

         ST_DONE: begin
            stop_d  = 1'b1;
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         state_q <= ST_IDLE;
         r_q     <= 32'd0;
         q_q     <= 32'd0;
         d_q     <= 32'd0;
         cnt_q   <= 6'd0;
         sq_q    <= 1'b0;
         sr_q    <= 1'b0;
         stop_q  <= 1'b0;
         hi_q    <= 32'd0;
         lo_q    <= 32'd0;
         zero_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         r_q     <= r_d;
         q_q     <= q_d;
         d_q     <= d_d;
         cnt_q   <= cnt_d;
         sq_q    <= sq_d;
         sr_q    <= sr_d;
         stop_q  <= stop_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         zero_q  <= zero_d;
      end
   end

   assign w_DivStop = stop_q;
   assign w_DIVHI   = hi_q;
   assign w_DIVLO   = lo_q;
   assign w_DivZero = zero_q;

endmodule
`default_nettype wire

// File: tb/tb_div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_div_unit
//  Description : Directed self-checking bench for div_unit.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_div_unit;

   logic        Clock;
   logic        Reset;
   logic        w_DivStart;
   logic [31:0] w_A;
   logic [31:0] w_B;
   logic        w_DivStop;
   logic [31:0] w_DIVHI;
   logic [31:0] w_DIVLO;
   logic        w_DivZero;

   int n_total = 0;
   int n_pass  = 0;

   div_unit dut (
      .Clock      (Clock),
      .Reset      (Reset),
      .w_DivStart (w_DivStart),
      .w_A        (w_A),
      .w_B        (w_B),
      .w_DivStop  (w_DivStop),
      .w_DIVHI    (w_DIVHI),
      .w_DIVLO    (w_DIVLO),
      .w_DivZero  (w_DivZero)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
   endtask

   // Issue one division, wait (bounded) for the stop pulse, then check
   // results, latency and pulse width. poke toggles start with A=B=1
   // mid-run, which must be ignored.
   task automatic divide(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_lo, input logic [31:0] exp_hi,
                         input logic exp_zero, input int exp_lat, input bit poke);
      int lat;
      @(negedge Clock);
      w_A = a;
      w_B = b;
      w_DivStart = 1'b1;
      @(posedge Clock);
      #1;
      w_DivStart = 1'b0;
      w_A = 32'hDEAD_BEEF;
      w_B = 32'h0000_0003;
      lat = 0;
      while (lat < 60) begin
         @(posedge Clock);
         #1;
         lat++;
         if (poke && lat == 5) begin
            w_A = 32'd1;
            w_B = 32'd1;
            w_DivStart = 1'b1;
         end
         if (poke && lat == 8) w_DivStart = 1'b0;
         if (w_DivStop) break;
      end
      check({tag, "_lat"}, lat, exp_lat);
      check({tag, "_lo"}, w_DIVLO, exp_lo);
      check({tag, "_hi"}, w_DIVHI, exp_hi);
      check({tag, "_zero"}, {31'd0, w_DivZero}, {31'd0, exp_zero});
      @(posedge Clock);
      #1;
      check({tag, "_pulse"}, {31'd0, w_DivStop}, 32'd0);
      check({tag, "_hold_lo"}, w_DIVLO, exp_lo);
   endtask

   initial begin
      logic signed [31:0] sa, sb;
      int seen;

      Reset      = 1'b0;
      w_DivStart = 1'b0;
      w_A        = 32'd0;
      w_B        = 32'd0;
      repeat (3) @(posedge Clock);
      #1;
      check("rst_stop", {31'd0, w_DivStop}, 32'd0);
      check("rst_hi", w_DIVHI, 32'd0);
      check("rst_lo", w_DIVLO, 32'd0);
      check("rst_zero", {31'd0, w_DivZero}, 32'd0);
      @(negedge Clock);
      Reset = 1'b1;

      divide("d100_7",   32'd100,           32'd7,           32'd14,          32'd2,           1'b0, 34, 1'b0);
      divide("dm100_7",  32'hFFFF_FF9C,     32'd7,           32'hFFFF_FFF2,   32'hFFFF_FFFE,   1'b0, 34, 1'b0);
      divide("d100_m7",  32'd100,           32'hFFFF_FFF9,   32'hFFFF_FFF2,   32'd2,           1'b0, 34, 1'b0);
      divide("dm100_m7", 32'hFFFF_FF9C,     32'hFFFF_FFF9,   32'd14,          32'hFFFF_FFFE,   1'b0, 34, 1'b0);
      divide("dmin_m1",  32'h8000_0000,     32'hFFFF_FFFF,   32'h8000_0000,   32'd0,           1'b0, 34, 1'b0);
      divide("dmin_1",   32'h8000_0000,     32'd1,           32'h8000_0000,   32'd0,           1'b0, 34, 1'b0);
      divide("d5_9",     32'd5,             32'd9,           32'd0,           32'd5,           1'b0, 34, 1'b0);
      divide("dzero",    32'h1234_5678,     32'd0,           32'hFFFF_FFFF,   32'h1234_5678,   1'b1, 1,  1'b0);
      // A normal divide after a zero divide clears the flag.
      divide("poke",     32'd100,           32'd7,           32'd14,          32'd2,           1'b0, 34, 1'b1);

      // Asynchronous reset mid-operation.
      @(negedge Clock);
      w_A = 32'd1000;
      w_B = 32'd3;
      w_DivStart = 1'b1;
      @(posedge Clock);
      #1;
      w_DivStart = 1'b0;
      repeat (9) @(posedge Clock);
      #3;
      Reset = 1'b0;
      #1;
      check("arst_stop", {31'd0, w_DivStop}, 32'd0);
      check("arst_hi", w_DIVHI, 32'd0);
      check("arst_lo", w_DIVLO, 32'd0);
      check("arst_zero", {31'd0, w_DivZero}, 32'd0);
      @(negedge Clock);
      Reset = 1'b1;
      seen = 0;
      repeat (40) begin
         @(posedge Clock);
         #1;
         if (w_DivStop) seen++;
      end
      check("arst_nostop", seen, 0);
      check("arst_lo_held", w_DIVLO, 32'd0);
      divide("after_rst", 32'd1000, 32'd3, 32'd333, 32'd1, 1'b0, 34, 1'b0);

      // Random signed pairs against the language's truncating / and %.
      for (int i = 0; i < 6; i++) begin
         sa = $urandom;
         sb = $urandom;
         if (i % 2 == 1) sb = 32'($signed(32'($urandom_range(0, 200)) - 100));
         if (sb == 0) sb = 32'sd1;
         if (sa == 32'sh8000_0000 && sb == -32'sd1) sb = 32'sd3;
         divide($sformatf("rnd%0d", i), sa, sb, sa / sb, sa % sb, 1'b0, 34, 1'b0);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
